// File: rtl/sci_pkg.sv
// Shared types for the SCI peripheral endpoint.
package sci_pkg;

    // Transaction phases of the slave FSM.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        WACK  = 3'd3,
        RWAIT = 3'd4,
        RDATA = 3'd5,
        HOLD  = 3'd6
    } sci_slave_state_t;

endpackage

// File: rtl/sci_slave.sv
// SCI slave endpoint: deserializes the master's request stream into a
// register-file access and answers on the shared tri-state resp/ack lines.
module sci_slave
    import sci_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sci_csn,
    input  logic                  sci_req,
    output tri                    sci_resp,
    output tri                    sci_ack,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [DATA_WIDTH-1:0] reg_wr_data,
    output logic                  reg_wr_en,
    output logic                  reg_rd_en,
    input  logic [DATA_WIDTH-1:0] reg_rd_data
);

    localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(MAX_W + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    // Reads spend one extra ADDR cycle with the counter parked here while
    // the read strobe is out, so the register file has its cycle of latency.
    localparam logic [CNT_W-1:0] ADDR_DONE = CNT_W'(ADDR_WIDTH);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);

    sci_slave_state_t        state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    wnr_q, wnr_d;
    logic [MAX_W-2:0]        in_sh_q, in_sh_d;
    logic [DATA_WIDTH-1:0]   out_sh_q, out_sh_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    wr_en_q, wr_en_d;
    logic                    rd_en_q, rd_en_d;

    // Input shift register with the current request bit appended at the MSB
    // end; the newest W bits of the word sit in its top W positions.
    logic [MAX_W-1:0]        in_word_s;
    logic                    bus_en_s;
    logic                    ack_val_s;
    logic                    resp_val_s;

    assign in_word_s = {sci_req, in_sh_q};

    // Next-state, shift and strobe logic for the transaction FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wnr_d    = wnr_q;
        in_sh_d  = in_sh_q;
        out_sh_d = out_sh_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wr_en_d  = 1'b0;
        rd_en_d  = 1'b0;
        if ((state_q != IDLE) && (state_q != HOLD) && sci_csn) begin
            // Master deselected mid-transfer: drop everything, no strobe.
            state_d  = IDLE;
            cnt_d    = CNT_ZERO;
            in_sh_d  = {(MAX_W-1){1'b0}};
            out_sh_d = {DATA_WIDTH{1'b0}};
        end else begin
            case (state_q)
                IDLE: begin
                    if (!sci_csn) begin
                        wnr_d   = sci_req;
                        cnt_d   = CNT_ZERO;
                        in_sh_d = {(MAX_W-1){1'b0}};
                        state_d = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADDR: begin
                    if (cnt_q == ADDR_DONE) begin
                        state_d = RWAIT;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        in_sh_d = in_word_s[MAX_W-1:1];
                        if (cnt_q == ADDR_LAST) begin
                            addr_d = in_word_s[MAX_W-1 -: ADDR_WIDTH];
                            if (wnr_q) begin
                                state_d = WDATA;
                                cnt_d   = CNT_ZERO;
                            end else begin
                                rd_en_d = 1'b1;
                                cnt_d   = ADDR_DONE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end
                end
                WDATA: begin
                    in_sh_d = in_word_s[MAX_W-1:1];
                    if (cnt_q == DATA_LAST) begin
                        wdata_d = in_word_s[MAX_W-1 -: DATA_WIDTH];
                        wr_en_d = 1'b1;
                        cnt_d   = CNT_ZERO;
                        state_d = WACK;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                WACK: begin
                    state_d = HOLD;
                end
                RWAIT: begin
                    out_sh_d = reg_rd_data;
                    cnt_d    = CNT_ZERO;
                    state_d  = RDATA;
                end
                RDATA: begin
                    out_sh_d = {1'b0, out_sh_q[DATA_WIDTH-1:1]};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d   = CNT_ZERO;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                HOLD: begin
                    if (sci_csn) begin
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // State, shift registers and register-file outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= CNT_ZERO;
            wnr_q    <= 1'b0;
            in_sh_q  <= {(MAX_W-1){1'b0}};
            out_sh_q <= {DATA_WIDTH{1'b0}};
            addr_q   <= {ADDR_WIDTH{1'b0}};
            wdata_q  <= {DATA_WIDTH{1'b0}};
            wr_en_q  <= 1'b0;
            rd_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wnr_q    <= wnr_d;
            in_sh_q  <= in_sh_d;
            out_sh_q <= out_sh_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wr_en_q  <= wr_en_d;
            rd_en_q  <= rd_en_d;
        end
    end

    // Bus response values; released combinationally on csn so the master
    // always finds the lines floating when it starts a transaction.
    always_comb begin
        bus_en_s   = (state_q != IDLE) && !sci_csn;
        ack_val_s  = 1'b0;
        resp_val_s = 1'b0;
        case (state_q)
            WACK, HOLD: begin
                ack_val_s = 1'b1;
            end
            RDATA: begin
                ack_val_s  = 1'b1;
                resp_val_s = out_sh_q[0];
            end
            default: begin
                ack_val_s  = 1'b0;
                resp_val_s = 1'b0;
            end
        endcase
    end

    assign sci_ack     = bus_en_s ? ack_val_s  : 1'bz;
    assign sci_resp    = bus_en_s ? resp_val_s : 1'bz;
    assign reg_addr    = addr_q;
    assign reg_wr_data = wdata_q;
    assign reg_wr_en   = wr_en_q;
    assign reg_rd_en   = rd_en_q;

endmodule

// File: tb/tb_sci_slave.sv
// Self-checking bench: two slaves on one pulled-up bus, each with its own
// register file, driven by a cycle-level master and checked every cycle
// against expectations derived from the transaction timeline.
module tb_sci_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        csn0, csn1, req;
    tri1         bus_ack, bus_resp;

    logic [7:0]  s0_addr, s1_addr;
    logic [15:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata;
    logic        s0_wr, s1_wr, s0_rd, s1_rd;

    // register-file side
    logic [15:0] rf0 [256];
    logic [15:0] rf1 [256];
    logic        pre_we0, pre_we1;
    logic [7:0]  pre_addr;
    logic [15:0] pre_data;

    // behavioural reference contents
    logic [15:0] ref_mem [2][256];

    // expectations for the current cycle
    logic        chk_en = 1'b0;
    logic        exp_ack, exp_resp, chk_zero;
    logic [1:0]  exp_wr, exp_rd;
    logic [7:0]  exp_addr;
    logic [15:0] exp_wd;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          n_wr0  = 0;
    int          n_rd0  = 0;

    always #5 clk = ~clk;

    sci_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) u_s0 (
        .clk(clk), .rst(rst), .sci_csn(csn0), .sci_req(req),
        .sci_resp(bus_resp), .sci_ack(bus_ack),
        .reg_addr(s0_addr), .reg_wr_data(s0_wdata),
        .reg_wr_en(s0_wr), .reg_rd_en(s0_rd), .reg_rd_data(s0_rdata));

    sci_slave #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) u_s1 (
        .clk(clk), .rst(rst), .sci_csn(csn1), .sci_req(req),
        .sci_resp(bus_resp), .sci_ack(bus_ack),
        .reg_addr(s1_addr), .reg_wr_data(s1_wdata),
        .reg_wr_en(s1_wr), .reg_rd_en(s1_rd), .reg_rd_data(s1_rdata));

    // trivial register files: write strobe, read data one cycle after strobe
    always @(posedge clk) begin
        if (pre_we0) rf0[pre_addr] <= pre_data;
        if (pre_we1) rf1[pre_addr] <= pre_data;
        if (s0_wr) rf0[s0_addr] <= s0_wdata;
        if (s1_wr) rf1[s1_addr] <= s1_wdata;
        if (s0_rd) s0_rdata <= rf0[s0_addr];
        if (s1_rd) s1_rdata <= rf1[s1_addr];
    end

    // strobe pulse counters
    always @(negedge clk) begin
        if (s0_wr === 1'b1) n_wr0 <= n_wr0 + 1;
        if (s0_rd === 1'b1) n_rd0 <= n_rd0 + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // per-cycle comparison against the expectations
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            chk("bus_ack", 32'(bus_ack), 32'(exp_ack));
            chk("bus_resp", 32'(bus_resp), 32'(exp_resp));
            chk("s0_wr_en", 32'(s0_wr), 32'(exp_wr[0]));
            chk("s0_rd_en", 32'(s0_rd), 32'(exp_rd[0]));
            chk("s1_wr_en", 32'(s1_wr), 32'(exp_wr[1]));
            chk("s1_rd_en", 32'(s1_rd), 32'(exp_rd[1]));
            if (exp_wr[0] | exp_rd[0]) chk("s0_addr", 32'(s0_addr), 32'(exp_addr));
            if (exp_wr[0]) chk("s0_wdata", 32'(s0_wdata), 32'(exp_wd));
            if (exp_wr[1] | exp_rd[1]) chk("s1_addr", 32'(s1_addr), 32'(exp_addr));
            if (exp_wr[1]) chk("s1_wdata", 32'(s1_wdata), 32'(exp_wd));
            if (chk_zero) begin
                chk("rst_s0_addr", 32'(s0_addr), 32'd0);
                chk("rst_s0_wdata", 32'(s0_wdata), 32'd0);
                chk("rst_s1_addr", 32'(s1_addr), 32'd0);
                chk("rst_s1_wdata", 32'(s1_wdata), 32'd0);
            end
        end
    end

    task automatic set_idle_exp();
        exp_ack  = 1'b1;   // released bus reads as the pull-up
        exp_resp = 1'b1;
        exp_wr   = 2'b00;
        exp_rd   = 2'b00;
        chk_zero = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        set_idle_exp();
        csn0 = 1'b1;
        csn1 = 1'b1;
        req  = 1'($urandom_range(0, 1));
        pre_we0 = 1'b0;
        pre_we1 = 1'b0;
    endtask

    task automatic preload(input int pid, input logic [7:0] a, input logic [15:0] d);
        @(negedge clk);
        if (!rst) set_idle_exp();
        csn0 = 1'b1;
        csn1 = 1'b1;
        pre_we0 = (pid == 0);
        pre_we1 = (pid == 1);
        pre_addr = a;
        pre_data = d;
        ref_mem[pid][a] = d;
    endtask

    // One master transaction, cycle by cycle. Cycle 0 carries WnR, 1..8 the
    // address, 9..24 the write data. Write: strobe+ack in cycle 25, hold after.
    // Read: strobe in 9, wait in 10, data beats 11..26, hold after.
    task automatic xact(input int pid, input bit wnr, input logic [7:0] a,
                        input logic [15:0] d, input int abort_at, input int rst_at,
                        input int hold, output logic [15:0] rx);
        int last;
        last = wnr ? (25 + hold) : (26 + hold);
        if (abort_at > 0) last = abort_at - 1;
        if (rst_at > 0) last = rst_at;
        rx = 16'h0000;
        for (int c = 0; c <= last + 1; c++) begin
            @(negedge clk);
            set_idle_exp();
            pre_we0 = 1'b0;
            pre_we1 = 1'b0;
            csn0 = 1'b1;
            csn1 = 1'b1;
            req  = 1'($urandom_range(0, 1));
            exp_addr = a;
            exp_wd   = d;
            if (rst_at > 0 && c >= rst_at) begin
                rst = 1'b1;
                chk_zero = 1'b1;
                if (c == rst_at) begin
                    if (pid == 0) csn0 = 1'b0; else csn1 = 1'b0;
                    req = d[c - 9];
                end
            end else if (c <= last) begin
                if (pid == 0) csn0 = 1'b0; else csn1 = 1'b0;
                if (c == 0) req = wnr;
                else if (c <= 8) req = a[c - 1];
                else if (wnr && c <= 24) req = d[c - 9];
                if (c >= 1) begin
                    if (wnr) begin
                        exp_ack  = (c >= 25);
                        exp_resp = 1'b0;
                        if (c == 25) exp_wr[pid] = 1'b1;
                    end else begin
                        exp_ack  = (c >= 11);
                        exp_resp = (c >= 11 && c <= 26) ? d[c - 11] : 1'b0;
                        if (c == 9) exp_rd[pid] = 1'b1;
                    end
                end
                if (!wnr && c >= 11 && c <= 26) begin
                    #2;
                    rx[c - 11] = bus_resp;
                end
            end
        end
        if (wnr && abort_at <= 0 && rst_at <= 0) ref_mem[pid][a] = d;
    endtask

    logic [15:0] rx;
    logic [7:0]  ra;
    logic [15:0] rd;
    int          wr_before, rd_before;

    initial begin
        rst = 1'b1;
        csn0 = 1'b1;
        csn1 = 1'b1;
        req = 1'b0;
        pre_we0 = 1'b0;
        pre_we1 = 1'b0;
        pre_addr = 8'h00;
        pre_data = 16'h0000;
        set_idle_exp();
        exp_addr = 8'h00;
        exp_wd = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        // reset state: bus released, strobes low, registers zero
        set_idle_exp();
        chk_zero = 1'b1;
        chk_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ra = 8'(i);
            preload(0, ra, {ra, ~ra});
            chk_zero = 1'b1;
        end
        for (int i = 0; i < 256; i++) begin
            ra = 8'(i);
            preload(1, ra, {~ra, ra});
            chk_zero = 1'b1;
        end
        @(negedge clk);
        pre_we1 = 1'b0;
        rst = 1'b0;
        set_idle_exp();
        chk_zero = 1'b1;
        idle_cycle();

        // directed write
        wr_before = n_wr0;
        xact(0, 1'b1, 8'hA5, 16'h1234, 0, 0, 1, rx);
        idle_cycle();
        chk("wr_pulse_count", 32'(n_wr0 - wr_before), 32'd1);
        xact(0, 1'b0, 8'hA5, ref_mem[0][8'hA5], 0, 0, 0, rx);
        chk("readback_A5", 32'(rx), 32'h0000_1234);

        // directed read of a preloaded value
        preload(0, 8'h3C, 16'hBEEF);
        idle_cycle();
        rd_before = n_rd0;
        xact(0, 1'b0, 8'h3C, ref_mem[0][8'h3C], 0, 0, 2, rx);
        chk("read_3C", 32'(rx), 32'h0000_BEEF);
        chk("rd_pulse_count", 32'(n_rd0 - rd_before), 32'd1);

        // second slave on the same bus
        xact(1, 1'b1, 8'h42, 16'hCAFE, 0, 0, 0, rx);
        xact(1, 1'b0, 8'h42, ref_mem[1][8'h42], 0, 0, 1, rx);
        chk("read_s1_42", 32'(rx), 32'h0000_CAFE);
        xact(0, 1'b0, 8'h42, ref_mem[0][8'h42], 0, 0, 0, rx);
        chk("read_s0_42", 32'(rx), 32'h0000_42BD);

        // abort after four address bits, then a normal write
        wr_before = n_wr0;
        xact(0, 1'b1, 8'h01, 16'hAAAA, 5, 0, 0, rx);
        chk("abort_no_wr", 32'(n_wr0 - wr_before), 32'd0);
        xact(0, 1'b1, 8'h01, 16'h0001, 0, 0, 0, rx);
        xact(0, 1'b0, 8'h01, ref_mem[0][8'h01], 0, 0, 0, rx);
        chk("read_01", 32'(rx), 32'h0000_0001);

        // reset during data bit 7 of a write
        wr_before = n_wr0;
        xact(0, 1'b1, 8'h77, 16'h5555, 0, 16, 0, rx);
        @(negedge clk);
        rst = 1'b0;
        set_idle_exp();
        chk_zero = 1'b1;
        idle_cycle();
        chk("reset_no_wr", 32'(n_wr0 - wr_before), 32'd0);
        xact(0, 1'b0, 8'h77, ref_mem[0][8'h77], 0, 0, 0, rx);
        chk("read_77_after_rst", 32'(rx), 32'h0000_7788);

        // back-to-back write then read, no idle gap
        xact(0, 1'b1, 8'h00, 16'hFFFF, 0, 0, 0, rx);
        xact(0, 1'b0, 8'h00, ref_mem[0][8'h00], 0, 0, 0, rx);
        chk("b2b_read_00", 32'(rx), 32'h0000_FFFF);

        // randomized traffic
        for (int n = 0; n < 60; n++) begin
            int pid, ab, hold, gap;
            bit wnr;
            pid  = $urandom_range(0, 1);
            wnr  = 1'($urandom_range(0, 1));
            ra   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            rd   = wnr ? 16'($urandom) : ref_mem[pid][ra];
            ab   = ($urandom_range(0, 7) == 0) ? $urandom_range(1, wnr ? 24 : 8) : 0;
            hold = $urandom_range(0, 3);
            gap  = $urandom_range(0, 2);
            xact(pid, wnr, ra, rd, ab, 0, hold, rx);
            if (!wnr && ab == 0) chk("rand_read", 32'(rx), 32'(rd));
            for (int g = 0; g < gap; g++) idle_cycle();
        end

        idle_cycle();
        idle_cycle();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
